// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: stall causes,
// mem-wait FSM states and the watchdog counter width.
package pipe_hazard_ctrl_pkg;

   localparam int WAIT_CNT_W = 16;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_LOAD_USE = 2'd1,
      CAUSE_MEM_WAIT = 2'd2,
      CAUSE_REDIRECT = 2'd3
   } stall_cause_e;

   typedef enum logic {
      MW_IDLE = 1'b0,
      MW_WAIT = 1'b1
   } mem_wait_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait.sv
// Data-memory wait FSM with a saturating wait counter and a sticky
// timeout flag; the pipe is frozen while an access is outstanding.
module mem_wait_watchdog
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_req_valid,
   input  logic mem_ready,
   output logic mem_freeze,
   output logic mem_timeout
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(MEM_TIMEOUT);

   mem_wait_state_e         state_q, state_d;
   logic [WAIT_CNT_W-1:0]   wait_cnt_q;
   logic [WAIT_CNT_W-1:0]   wait_cnt_inc;

   // NOTE: registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) state_q <= MW_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      mem_freeze = 1'b0;
      case (state_q)
         MW_IDLE: begin
            if (mem_req_valid && !mem_ready) begin
               state_d    = MW_WAIT;
               mem_freeze = 1'b1;
            end
         end
         MW_WAIT: begin
            if (mem_ready) state_d    = MW_IDLE;
            else           mem_freeze = 1'b1;
         end
         default: state_d = MW_IDLE;
      endcase
   end

   // Saturate rather than wrap so a long hang cannot look like a fresh wait.
   assign wait_cnt_inc = (wait_cnt_q == {WAIT_CNT_W{1'b1}}) ? wait_cnt_q
                                                            : wait_cnt_q + 1'b1;

   // Every non-frozen cycle ends in IDLE, so clearing there covers
   // both the release edge and idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q  <= '0;
         mem_timeout <= 1'b0;
      end else begin
         wait_cnt_q <= mem_freeze ? wait_cnt_inc : '0;
         if (mem_freeze && wait_cnt_inc == TIMEOUT_LIM)
            mem_timeout <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline hazard controller: stage enables, flushes and bubbles.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  ex_reg_file_rd,
   input  logic        ex_data_mem_re,
   input  logic        ex_branch_taken,
   input  logic        trap_flush,
   input  logic        mem_req_valid,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        id_ex_en,
   output logic        ex_mem_en,
   output logic        mem_wb_en,
   output logic        if_id_flush,
   output logic        ex_mem_flush,
   output logic        id_stall,
   output logic [1:0]  stall_cause,
   output logic        mem_timeout
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_count
`endif
);

   logic         mem_freeze;
   logic         load_use;
   stall_cause_e cause;

   mem_wait_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait (
      .clk           (clk),
      .rst           (rst),
      .mem_req_valid (mem_req_valid),
      .mem_ready     (mem_ready),
      .mem_freeze    (mem_freeze),
      .mem_timeout   (mem_timeout)
   );

   assign load_use = ex_data_mem_re && (ex_reg_file_rd != 5'd0) &&
                     ((id_rs1_used && id_rs1 == ex_reg_file_rd) ||
                      (id_rs2_used && id_rs2 == ex_reg_file_rd));

   // Priority: reset, mem freeze, trap, branch, load-use, normal.
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      id_stall     = 1'b0;
      cause        = CAUSE_NONE;
      if (rst || mem_freeze) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
         if (!rst) cause = CAUSE_MEM_WAIT;
      end else if (trap_flush || ex_branch_taken) begin
         if_id_flush  = 1'b1;
         ex_mem_flush = trap_flush;
         id_stall     = 1'b1;
         cause        = CAUSE_REDIRECT;
      end else if (load_use) begin
         pc_en    = 1'b0;
         if_id_en = 1'b0;
         id_stall = 1'b1;
         cause    = CAUSE_LOAD_USE;
      end
   end

   assign stall_cause = cause;

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_flush_count  <= '0;
      end else begin
         if (cause == CAUSE_LOAD_USE || cause == CAUSE_MEM_WAIT)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (cause == CAUSE_REDIRECT)
            perf_flush_count <= perf_flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline hazard controller for the 5-stage core. It produces the per-stage enable, flush and bubble signals consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It resolves load-use hazards, taken-branch and trap redirects, and multi-cycle data-memory waits, and it supervises memory waits with a timeout watchdog. It sits beside the datapath and receives decode and hazard information from the ID, EX and MEM stages.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive data-memory wait cycles before `mem_timeout` sets; valid range 1..65535.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads rs1/rs2
- ex_reg_file_rd  in  5  destination register in EX
- ex_data_mem_re  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- trap_flush  in  1  exception or trap redirect, from MEM
- mem_req_valid  in  1  MEM stage presents a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage advance enables
- if_id_flush, ex_mem_flush  out  1 each  squash the register contents to a NOP
- id_stall  out  1  drives the ID/EX bubble/clear input
- stall_cause  out  2  0 none, 1 load-use, 2 mem-wait, 3 redirect
- mem_timeout  out  1  sticky watchdog flag

## Operation
- **Priority**, highest first: rst, mem-wait freeze, trap_flush, ex_branch_taken, load-use, normal.
- **Normal**
  - All enables are 1.
  - All flushes and id_stall are 0.
  - stall_cause is 0.
- **Load-use hazard**
  - Condition: ex_data_mem_re && ex_reg_file_rd!=0 && ((id_rs1_used && id_rs1==ex_reg_file_rd) || (id_rs2_used && id_rs2==ex_reg_file_rd)).
  - Response: pc_en=0, if_id_en=0, id_stall=1; all other enables stay 1.
  - stall_cause=1.
- **Branch redirect** (ex_branch_taken)
  - Response: if_id_flush=1, id_stall=1, pc_en=1.
  - stall_cause=3.
  - A simultaneous load-use condition is ignored because the ID instruction is on the wrong path.
- **Trap redirect** (trap_flush)
  - Response: the branch-redirect response plus ex_mem_flush=1.
  - stall_cause=3.
- **Mem-wait FSM**, states IDLE and WAIT.
  - IDLE -> WAIT when mem_req_valid && !mem_ready.
  - WAIT -> IDLE when mem_ready.
  - While the access is outstanding (IDLE with mem_req_valid && !mem_ready, or WAIT with !mem_ready):
    - all five enables are 0 and all flushes and id_stall are 0;
    - stall_cause=2;
    - redirect and load-use inputs are ignored and re-evaluated on the release cycle.
  - In the WAIT cycle where mem_ready=1, outputs follow the lower-priority rules.
- **Watchdog**
  - A 16-bit wait counter increments each frozen cycle and clears on entering IDLE.
  - mem_timeout sets when the counter reaches MEM_TIMEOUT. It stays set until rst.
  - The FSM keeps waiting after a timeout; there is no forced release.
- **Reset**
  - While rst=1: all enables 0, flushes 0, id_stall 0, stall_cause 0.
  - On reset, FSM returns to IDLE, the counter clears, mem_timeout clears and the perf counters clear.
  - Reset in WAIT abandons the access.

## Timing
- All outputs are combinational from the current inputs and registered state. There is no output latency.
- Load-use costs exactly one bubble cycle. The dependent instruction enters EX one cycle after the load.
- A taken branch costs two squashed slots (IF/ID and ID/EX).
- A memory access with ready arriving k cycles after the request freezes the pipe for k cycles. mem_ready in the request cycle costs 0 cycles.
- mem_timeout rises on the clock edge at which the counter reaches MEM_TIMEOUT.

## Configuration
- Macro: HAZARD_PERF_EN.
- Defined:
  - adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0];
  - perf_stall_cycles increments on every cycle with stall_cause 1 or 2;
  - perf_flush_count increments on every cycle with stall_cause 3;
  - both counters wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- The shared package holds:
  - stall_cause encodings (CAUSE_NONE, CAUSE_LOAD_USE, CAUSE_MEM_WAIT, CAUSE_REDIRECT);
  - FSM state constants;
  - the counter width.
- One natural sub-module, mem_wait_watchdog, holds the FSM, the wait counter and the sticky mem_timeout flag.
- Hazard comparison and priority logic stay in the top module.

## Test plan
- **Load-use:** EX load with rd=5, ID reads rs1=5 -> one cycle of pc_en=0, if_id_en=0, id_stall=1, stall_cause=1; next cycle all enables 1.
- **rd=x0:** EX load with rd=0, ID rs2=0 used -> no stall.
- **Branch with load-use:** ex_branch_taken=1 alongside a load-use match -> if_id_flush=1, id_stall=1, pc_en=1, stall_cause=3.
- **Mem wait:** mem_req_valid=1 with mem_ready low for 3 cycles -> all enables 0 for exactly 3 cycles, stall_cause=2; enables return to 1 on the ready cycle. A trap_flush raised during the wait is honoured only on the release cycle.
- **Watchdog:** MEM_TIMEOUT=4 and mem_ready held low 10 cycles -> mem_timeout rises after the 4th frozen cycle and stays 1 after ready. rst clears it.
- **Reset and perf:** rst asserted in WAIT -> FSM IDLE and enables 0 during rst. With HAZARD_PERF_EN, one load-use plus one 3-cycle wait gives perf_stall_cycles=4, and two branches give perf_flush_count=2.
